// File: rtl/pc_reg.sv
// Program-counter register for the single-cycle MIPS datapath: loads the next PC
// every edge, and provides PC+4, the instruction-memory word index and a fetch address-error flag.
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096,
    parameter int unsigned IM_AW    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      NPC,
    output logic [31:0]      PC,
    output logic [31:0]      PC4,
    output logic [IM_AW-1:0] im_addr,
    output logic             addr_err
);

    // Computed in 33 bits so the upper bound cannot wrap.
    localparam logic [32:0] IM_END = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

    logic [31:0] pc_d, pc_q;
    logic        addr_err_d, addr_err_q;
    logic        misaligned, below_base, above_top;

    always_comb begin
        misaligned = (NPC[1:0] != 2'b00);
        below_base = (NPC < RESET_PC);
        above_top  = ({1'b0, NPC} >= IM_END);

        pc_d       = {NPC[31:2], 2'b00};
        addr_err_d = misaligned | below_base | above_top;
        if (!reset) begin
            pc_d       = RESET_PC;
            addr_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        pc_q       <= pc_d;
        addr_err_q <= addr_err_d;
    end

    always_comb begin
        PC       = pc_q;
        PC4      = pc_q + 32'd4;
        im_addr  = IM_AW'((pc_q - RESET_PC) >> 2);
        addr_err = addr_err_q;
    end

endmodule

// File: tb/tb_pc_reg.sv
// Directed self-checking bench for pc_reg: reset, sequential fetch, jumps,
// misaligned and out-of-range targets, PC4 wrap and mid-run reset.
module tb_pc_reg;

    logic        clk;
    logic        reset;
    logic [31:0] NPC;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic [11:0] im_addr;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    pc_reg #(
        .RESET_PC (32'h0000_3000),
        .IM_WORDS (4096),
        .IM_AW    (12)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .NPC      (NPC),
        .PC       (PC),
        .PC4      (PC4),
        .im_addr  (im_addr),
        .addr_err (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample just after the rising edge.
    task automatic tick(input logic rst, input logic [31:0] npc);
        @(negedge clk);
        reset = rst;
        NPC   = npc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        NPC   = 32'h0;

        tick(1'b0, 32'h0);
        chk("rst_pc",   PC,              32'h0000_3000);
        chk("rst_pc4",  PC4,             32'h0000_3004);
        chk("rst_im",   32'(im_addr),    32'd0);
        chk("rst_err",  32'(addr_err),   32'd0);

        tick(1'b1, 32'h0000_3004);
        chk("seq1_pc",  PC,              32'h0000_3004);
        chk("seq1_im",  32'(im_addr),    32'd1);
        chk("seq1_err", 32'(addr_err),   32'd0);
        tick(1'b1, 32'h0000_3008);
        chk("seq2_pc",  PC,              32'h0000_3008);
        chk("seq2_im",  32'(im_addr),    32'd2);
        tick(1'b1, 32'h0000_300C);
        chk("seq3_pc",  PC,              32'h0000_300C);
        chk("seq3_im",  32'(im_addr),    32'd3);
        chk("seq3_err", 32'(addr_err),   32'd0);
        tick(1'b1, 32'h0000_3010);
        chk("seq4_pc",  PC,              32'h0000_3010);
        chk("seq4_pc4", PC4,             32'h0000_3014);
        chk("seq4_im",  32'(im_addr),    32'd4);

        tick(1'b1, 32'h0000_3100);
        chk("jmp_pc",   PC,              32'h0000_3100);
        chk("jmp_im",   32'(im_addr),    32'd64);
        chk("jmp_err",  32'(addr_err),   32'd0);

        tick(1'b1, 32'h0000_3006);
        chk("mis_pc",   PC,              32'h0000_3004);
        chk("mis_err",  32'(addr_err),   32'd1);
        tick(1'b1, 32'h0000_3008);
        chk("mis2_pc",  PC,              32'h0000_3008);
        chk("mis2_err", 32'(addr_err),   32'd0);

        tick(1'b1, 32'h0000_2FFC);
        chk("low_pc",   PC,              32'h0000_2FFC);
        chk("low_err",  32'(addr_err),   32'd1);
        chk("low_im",   32'(im_addr),    32'h0000_0FFF);

        tick(1'b1, 32'h0000_7000);
        chk("top_pc",   PC,              32'h0000_7000);
        chk("top_err",  32'(addr_err),   32'd1);
        chk("top_im",   32'(im_addr),    32'd0);

        tick(1'b1, 32'h0000_6FFC);
        chk("last_err", 32'(addr_err),   32'd0);
        chk("last_im",  32'(im_addr),    32'h0000_0FFF);

        tick(1'b1, 32'hFFFF_FFFC);
        chk("wrap_pc",  PC,              32'hFFFF_FFFC);
        chk("wrap_pc4", PC4,             32'h0000_0000);
        chk("wrap_err", 32'(addr_err),   32'd1);

        // Misaligned load leaves PC at 3100 with the error flag set before the reset.
        tick(1'b1, 32'h0000_3101);
        chk("pre_pc",   PC,              32'h0000_3100);
        chk("pre_err",  32'(addr_err),   32'd1);

        @(negedge clk);
        reset = 1'b0;
        NPC   = 32'h0000_4000;
        #2;
        chk("hold_pc",  PC,              32'h0000_3100);
        chk("hold_err", 32'(addr_err),   32'd1);
        @(posedge clk);
        #1;
        chk("mrst_pc",  PC,              32'h0000_3000);
        chk("mrst_err", 32'(addr_err),   32'd0);
        chk("mrst_im",  32'(im_addr),    32'd0);

        tick(1'b1, 32'h0000_3008);
        chk("rel_pc",   PC,              32'h0000_3008);
        chk("rel_im",   32'(im_addr),    32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
